fb_rect_filler: RTL and testbench

Bus-master fill engine that writes solid-colour rectangles into the 160×120, 3-bit-colour pixel framebuffer. It uses the framebuffer's CPU write port: active-low chip enable, RW low for write, and a byte address offset by the framebuffer base. The engine sits beside the 6502 on the shared framebuffer bus and requests ownership through a REQ/GRANT arbiter. The CPU issues one command and the engine generates every pixel write, so software no longer loops over addresses.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_rect_filler.sv | 162 ++++++++++++++++
 tb/tb_fb_rect_filler.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared constants, state encoding and clipping helper for the framebuffer fill engine.
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_BASE   = 4096;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    WRITE = 3'd3,
    GAP   = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Exclusive end coordinate of a span, clamped to the framebuffer edge.
  function automatic logic [8:0] clip_end(input logic [8:0] start,
                                          input logic [8:0] len,
                                          input logic [8:0] limit);
    logic [8:0] span_end;
    span_end = start + len;
    return (span_end > limit) ? limit : span_end;
  endfunction

endpackage

// File: rtl/fb_rect_filler.sv
// Solid-rectangle fill engine: clips a command to the framebuffer and issues one
// CPU-port write strobe per pixel while holding the bus through a REQ/GRANT arbiter.
module fb_rect_filler
  import fb_pkg::*;
#(
  parameter int WRITE_GAP = 0
) (
  input  logic        CLK_SYS,
  input  logic        RESET_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [7:0]  CMD_X,
  input  logic [6:0]  CMD_Y,
  input  logic [7:0]  CMD_W,
  input  logic [6:0]  CMD_H,
  input  logic [2:0]  CMD_COLOR,
  output logic        BUS_REQ,
  input  logic        BUS_GRANT,
  output logic [14:0] BUS_ADDR,
  output logic [6:0]  BUS_DATA,
  output logic        BUS_CE_N,
  output logic        BUS_RW,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [2:0]  GAP_LAST  = (WRITE_GAP > 0) ? 3'(WRITE_GAP - 1) : 3'd0;
  localparam logic [14:0] BASE_ADDR = 15'(FB_BASE);
  localparam logic [14:0] ROW_STEP  = 15'(FB_WIDTH);

  state_t      state;
  logic        setup_phase;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [2:0]  color;
  logic [8:0]  xe;
  logic [8:0]  ye;
  logic        empty;
  logic [8:0]  x;
  logic [8:0]  y;
  logic [14:0] row_base;
  logic [2:0]  gap_cnt;
  logic [14:0] bus_addr;
  logic [6:0]  bus_data;

  logic        last_col;
  logic        last_row;
  logic [8:0]  x_adv;
  logic [8:0]  y_adv;
  logic [14:0] row_adv;
  logic [14:0] pix_addr;
  logic [14:0] adv_addr;

  // Next-pixel raster step: wrap to the left column and move one row down.
  assign last_col = ((x + 9'd1) == xe);
  assign last_row = ((y + 9'd1) == ye);
  assign x_adv    = last_col ? {1'b0, cmd_x} : (x + 9'd1);
  assign y_adv    = last_col ? (y + 9'd1) : y;
  assign row_adv  = last_col ? (row_base + ROW_STEP) : row_base;
  assign pix_addr = BASE_ADDR + row_base + {6'b0, x};
  assign adv_addr = BASE_ADDR + row_adv + {6'b0, x_adv};

  always_ff @(posedge CLK_SYS or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      setup_phase <= 1'b0;
      cmd_x       <= '0;
      cmd_y       <= '0;
      cmd_w       <= '0;
      cmd_h       <= '0;
      color       <= '0;
      xe          <= '0;
      ye          <= '0;
      empty       <= 1'b0;
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
      gap_cnt     <= '0;
      bus_addr    <= '0;
      bus_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            cmd_x       <= CMD_X;
            cmd_y       <= CMD_Y;
            cmd_w       <= CMD_W;
            cmd_h       <= CMD_H;
            color       <= CMD_COLOR;
            setup_phase <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          // Clipped bounds are registered first; the branch uses them a cycle later.
          if (!setup_phase) begin
            xe          <= clip_end({1'b0, cmd_x}, {1'b0, cmd_w}, 9'(FB_WIDTH));
            ye          <= clip_end({2'b0, cmd_y}, {2'b0, cmd_h}, 9'(FB_HEIGHT));
            empty       <= ({1'b0, cmd_x} >= 9'(FB_WIDTH)) || ({2'b0, cmd_y} >= 9'(FB_HEIGHT)) ||
                           (cmd_w == 8'd0) || (cmd_h == 7'd0);
            x           <= {1'b0, cmd_x};
            y           <= {2'b0, cmd_y};
            row_base    <= ({8'b0, cmd_y} << 7) + ({8'b0, cmd_y} << 5);
            setup_phase <= 1'b1;
          end else begin
            state <= empty ? FIN : REQ;
          end
        end
        REQ: begin
          if (BUS_GRANT) begin
            bus_addr <= pix_addr;
            bus_data <= {4'b0, color};
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (!BUS_GRANT) begin
            state <= REQ;
          end else if (last_col && last_row) begin
            state <= FIN;
          end else begin
            x        <= x_adv;
            y        <= y_adv;
            row_base <= row_adv;
            if (WRITE_GAP > 0) begin
              gap_cnt <= 3'd0;
              state   <= GAP;
            end else begin
              bus_addr <= adv_addr;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= REQ;
          end else begin
            gap_cnt <= gap_cnt + 3'd1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobe is gated by grant directly so a revoked grant never produces a write.
  assign BUS_CE_N  = ~((state == WRITE) && BUS_GRANT);
  assign BUS_REQ   = (state == REQ) || (state == WRITE) || (state == GAP);
  assign BUS_RW    = ~BUS_REQ;
  assign CMD_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign DONE      = (state == FIN);
  assign BUS_ADDR  = bus_addr;
  assign BUS_DATA  = bus_data;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Scoreboarded bench for fb_rect_filler: expected writes are queued at command issue
// and a negedge monitor checks every strobe against them.
module tb_fb_rect_filler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [2:0]  cmd_color;
  logic        bus_req;
  logic        bus_grant;
  logic [14:0] bus_addr;
  logic [6:0]  bus_data;
  logic        bus_ce_n;
  logic        bus_rw;
  logic        busy;
  logic        done;

  logic        g_valid;
  logic        g_ready;
  logic        g_req;
  logic        g_grant;
  logic [14:0] g_addr;
  logic [6:0]  g_data;
  logic        g_ce_n;
  logic        g_rw;
  logic        g_busy;
  logic        g_done;

  always #5 clk = ~clk;

  fb_rect_filler u_dut (
    .CLK_SYS(clk), .RESET_N(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_X(cmd_x), .CMD_Y(cmd_y), .CMD_W(cmd_w), .CMD_H(cmd_h), .CMD_COLOR(cmd_color),
    .BUS_REQ(bus_req), .BUS_GRANT(bus_grant), .BUS_ADDR(bus_addr), .BUS_DATA(bus_data),
    .BUS_CE_N(bus_ce_n), .BUS_RW(bus_rw), .BUSY(busy), .DONE(done)
  );

  fb_rect_filler #(.WRITE_GAP(2)) u_gap (
    .CLK_SYS(clk), .RESET_N(rst_n),
    .CMD_VALID(g_valid), .CMD_READY(g_ready),
    .CMD_X(cmd_x), .CMD_Y(cmd_y), .CMD_W(cmd_w), .CMD_H(cmd_h), .CMD_COLOR(cmd_color),
    .BUS_REQ(g_req), .BUS_GRANT(g_grant), .BUS_ADDR(g_addr), .BUS_DATA(g_data),
    .BUS_CE_N(g_ce_n), .BUS_RW(g_rw), .BUSY(g_busy), .DONE(g_done)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;

  int  n_writes, first_ce, last_ce, req_first, done_cnt, done_cyc;
  int  g_n, g_rw_bad, g_done_cyc;
  int  g_cyc[4];
  int  g_addr_log[4];
  int  g_data_log[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pushw(input int addr, input int data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Main DUT monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (bus_req && req_first < 0) req_first = cyc;
      if (!bus_ce_n) begin
        n_writes++;
        if (first_ce < 0) first_ce = cyc;
        last_ce = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'(bus_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(bus_addr), e.addr);
          check("wr_data", int'(bus_data), e.data);
          check("wr_rw", int'(bus_rw), 0);
          $display("write addr=%0d data=%0d cycle=%0d", bus_addr, bus_data, cyc);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Gap DUT monitor: logs strobe cycles and RW behaviour while requesting.
  always @(negedge clk) begin
    if (rst_n) begin
      if (g_req && g_rw) g_rw_bad++;
      if (!g_ce_n) begin
        if (g_n < 4) begin
          g_cyc[g_n]      = cyc;
          g_addr_log[g_n] = int'(g_addr);
          g_data_log[g_n] = int'(g_data);
        end
        g_n++;
      end
      if (g_done) g_done_cyc = cyc;
    end
  end

  task automatic send_cmd(input int x, input int y, input int w, input int h, input int c,
                          output int acc);
    @(negedge clk);
    n_writes  = 0;
    first_ce  = -1;
    last_ce   = -1;
    req_first = -1;
    done_cyc  = -1;
    cmd_x     = 8'(x);
    cmd_y     = 7'(y);
    cmd_w     = 8'(w);
    cmd_h     = 7'(h);
    cmd_color = 3'(c);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
    $display("cmd x=%0d y=%0d w=%0d h=%0d color=%0d accepted cycle=%0d", x, y, w, h, c, acc);
  endtask

  task automatic wait_done(input int start_cnt, input string name);
    int k;
    k = 0;
    while (done_cnt == start_cnt && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == start_cnt) check({name, "_done_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, d0, k;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    g_valid   = 1'b0;
    bus_grant = 1'b1;
    g_grant   = 1'b1;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    done_cnt = 0; g_n = 0; g_rw_bad = 0; g_done_cyc = -1;
    n_writes = 0; first_ce = -1; last_ce = -1; req_first = -1; done_cyc = -1;

    // Reset values, sampled while reset is held.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bus_req", int'(bus_req), 0);
    check("rst_ce_n", int'(bus_ce_n), 1);
    check("rst_rw", int'(bus_rw), 1);
    check("rst_addr", int'(bus_addr), 0);
    check("rst_data", int'(bus_data), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 2x2 at origin: back-to-back strobes starting 3 cycles after accept.
    pushw(4096, 5); pushw(4097, 5); pushw(4256, 5); pushw(4257, 5);
    d0 = done_cnt;
    send_cmd(0, 0, 2, 2, 5, a);
    wait_done(d0, "t1");
    check("t1_req_rise", req_first, a + 2);
    check("t1_first_ce", first_ce, a + 3);
    check("t1_last_ce", last_ce, a + 6);
    check("t1_n_writes", n_writes, 4);
    check("t1_done_cyc", done_cyc, a + 7);
    check("t1_queue_left", exp_q.size(), 0);

    // Bottom-right corner clip.
    pushw(23134, 2); pushw(23135, 2); pushw(23294, 2); pushw(23295, 2);
    d0 = done_cnt;
    send_cmd(158, 118, 5, 5, 2, a);
    wait_done(d0, "t2");
    check("t2_n_writes", n_writes, 4);
    check("t2_done_cyc", done_cyc, a + 7);
    check("t2_queue_left", exp_q.size(), 0);

    // Degenerate: zero width, then X off-screen.
    d0 = done_cnt;
    send_cmd(5, 5, 0, 3, 1, a);
    wait_done(d0, "t3a");
    check("t3a_n_writes", n_writes, 0);
    check("t3a_req_seen", req_first, -1);
    check("t3a_done_cyc", done_cyc, a + 2);
    d0 = done_cnt;
    send_cmd(200, 5, 4, 3, 1, a);
    wait_done(d0, "t3b");
    check("t3b_n_writes", n_writes, 0);
    check("t3b_req_seen", req_first, -1);
    check("t3b_done_cyc", done_cyc, a + 2);

    // Grant dropped for 3 cycles after the second write.
    pushw(5706, 7); pushw(5707, 7); pushw(5708, 7); pushw(5709, 7);
    d0 = done_cnt;
    send_cmd(10, 10, 4, 1, 7, a);
    k = 0;
    while (n_writes < 2 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("t4_reach_two", n_writes, 2);
    #1;
    bus_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus_grant = 1'b1;
    wait_done(d0, "t4");
    check("t4_n_writes", n_writes, 4);
    check("t4_span", last_ce - first_ce, 7);
    check("t4_queue_left", exp_q.size(), 0);

    // Gap engine: strobes every 4 cycles, RW low while requesting.
    @(negedge clk);
    cmd_x = 8'd0; cmd_y = 7'd0; cmd_w = 8'd3; cmd_h = 7'd1; cmd_color = 3'd6;
    g_valid = 1'b1;
    @(posedge clk);
    #1;
    g_valid = 1'b0;
    a = cyc;
    $display("gap cmd x=0 y=0 w=3 h=1 color=6 accepted cycle=%0d", a);
    k = 0;
    while (g_done_cyc < 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    check("t5_n_writes", g_n, 3);
    check("t5_first_ce", g_cyc[0], a + 3);
    check("t5_spacing1", g_cyc[1] - g_cyc[0], 4);
    check("t5_spacing2", g_cyc[2] - g_cyc[1], 4);
    check("t5_addr0", g_addr_log[0], 4096);
    check("t5_addr2", g_addr_log[2], 4098);
    check("t5_data1", g_data_log[1], 6);
    check("t5_rw_bad", g_rw_bad, 0);
    check("t5_done_cyc", g_done_cyc, a + 12);

    // Asynchronous reset in the middle of a 10x2 fill.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 10; c++) pushw(4096 + r * 160 + c, 3);
    d0 = done_cnt;
    send_cmd(0, 0, 10, 2, 3, a);
    k = 0;
    while (n_writes < 3 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("t6_pre_ce_n", int'(bus_ce_n), 0);
    rst_n = 1'b0;
    #1;
    check("t6_ce_n", int'(bus_ce_n), 1);
    check("t6_bus_req", int'(bus_req), 0);
    check("t6_rw", int'(bus_rw), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("t6_cmd_ready", int'(cmd_ready), 1);
    check("t6_busy", int'(busy), 0);
    check("t6_no_done", done_cnt, d0);
    check("t6_n_writes", n_writes, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
